instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 12, instruction word address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, instruction width.
REQ-003 SHALL have parameter RESET_PC, default 0, first fetch address.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port rom_addr  out  ADDRESS_WIDTH  word address to instruction ROM; equals PC register.
REQ-007 SHALL have port rom_data  in  DATA_WIDTH  ROM output; ROM samples rom_addr on falling edge, so word is valid at next rising edge.
REQ-008 SHALL have port redirect_valid  in  1  branch/jump taken; flush and reload PC.
REQ-009 SHALL have port redirect_pc  in  ADDRESS_WIDTH  new PC when redirect_valid.
REQ-010 SHALL have port halt_req  in  1  stop fetching until next redirect.
REQ-011 SHALL have port out_valid  out  1  out_instr/out_pc hold a fetched word.
REQ-012 SHALL have port out_ready  in  1  decode accepts; transfer when out_valid && out_ready.
REQ-013 SHALL have port out_instr  out  DATA_WIDTH  fetched instruction.
REQ-014 SHALL have port out_pc  out  ADDRESS_WIDTH  address of out_instr.

Function
REQ-015 SHALL hold fetched {pc, instr} pairs in a 2-entry FIFO; out_* driven from FIFO head; out_valid = FIFO non-empty.
REQ-016 SHALL implement FSM states BOOT, RUN, HALT; BOOT -> RUN on first rising edge after reset release with no push.
REQ-017 In RUN, "fetch" SHALL occur at an edge iff !redirect_valid && !halt_req && (count < 2 || pop), where pop = out_valid && out_ready.
REQ-018 On fetch, SHALL push {PC, rom_data} and set PC <= PC + 1, wrapping from 2^ADDRESS_WIDTH-1 to 0.
REQ-019 When not fetching, SHALL hold PC, so rom_addr and rom_data remain stable.
REQ-020 Simultaneous push and pop at count 2 SHALL keep count at 2 with order preserved; at count 0, push only, no bypass.
REQ-021 redirect_valid in any state SHALL, at that edge: empty FIFO, PC <= redirect_pc, state <= RUN, no push (in-flight rom_data discarded).
REQ-022 redirect_valid SHALL take priority over halt_req and over a concurrent pop; a pop handshake in that cycle still counts as accepted by decode.
REQ-023 halt_req in RUN (without redirect) SHALL block the push at that edge and move to HALT; FIFO keeps draining in HALT; no fetch in HALT.
REQ-024 Redirect-to-output latency SHALL be 2 edges: redirect at edge N, push of redirect_pc at N+1, out_valid high after N+1.
REQ-025 Steady state with out_ready=1 SHALL deliver one instruction per cycle.

Reset
REQ-026 reset_n low SHALL immediately force PC=RESET_PC, state=BOOT, FIFO empty, out_valid=0, out_instr=0, out_pc=0, independent of clk.
REQ-027 Reset asserted mid-operation SHALL discard all buffered words; first out_valid SHALL occur after the 2nd rising edge following release.

Structure
REQ-028 SHALL place the FSM state enum (BOOT/RUN/HALT) and default RESET_PC in shared package fetch_pkg.
REQ-029 SHALL implement the FIFO as sub-module fetch_fifo (2 entries, push/pop/flush, count output, async active-low reset).

Verification
REQ-030 Reset release, ROM[i]=i+100, out_ready=1 -> out_valid after edge 2, then (pc,instr) = (0,100),(1,101),(2,102)... one per cycle.
REQ-031 out_ready=0 for 5 cycles -> count saturates at 2, PC stops at 2, rom_addr stable; out_ready=1 -> pc 0,1,2,3 in order, no gaps/duplicates.
REQ-032 Redirect to 0x040 while FIFO holds 2 words -> out_valid low next cycle, next delivered pair (0x040, ROM[0x040]) after 2 edges.
REQ-033 halt_req pulse at pc 5 -> words up to pc 4 drain, out_valid then stays 0; later redirect to 0x010 resumes at 0x010.
REQ-034 RESET_PC=0xFFE, ADDRESS_WIDTH=12 -> pc sequence 0xFFE, 0xFFF, 0x000; redirect and halt_req same cycle -> redirect wins, RUN.
REQ-035 reset_n low between edges with FIFO full -> out_valid=0 immediately, PC=RESET_PC, and REQ-030 sequence restarts.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch unit
//
// Purpose: holds the fetch FSM state encoding, the default first-fetch
// address and the depth of the fetched-word buffer.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  localparam int unsigned DEFAULT_RESET_PC = 0;
  localparam int unsigned FIFO_DEPTH       = 2;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - two-entry FIFO with flush for fetched {pc, instr} pairs
//
// Purpose: buffers fetched words between the ROM and decode.
// Ports:
//   clk      in   clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   push_i   in   write data_i at this edge
//   pop_i    in   drop the head entry at this edge
//   flush_i  in   empty the FIFO (wins over push and pop)
//   data_i   in   entry to write
//   data_o   out  head entry, zero while empty
//   count_o  out  number of valid entries (0..2)
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned WIDTH = 44
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic [1:0]       count_o
);

  localparam logic [1:0] FULL = 2'(FIFO_DEPTH);

  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic [1:0]       count_q, count_d;
  logic             pop_ok, push_ok;

  // A pop on an empty FIFO is ignored; a push into a full FIFO is only
  // accepted when the same edge frees a slot.
  assign pop_ok  = pop_i && (count_q != 2'd0);
  assign push_ok = push_i && ((count_q != FULL) || pop_ok);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      count_d = 2'd0;
    end else begin
      if (pop_ok) begin
        head_d = tail_q;
      end
      if (push_ok) begin
        // New word lands in the head slot when it will be the only entry.
        if ((count_q == 2'd0) || ((count_q == 2'd1) && pop_ok)) begin
          head_d = data_i;
        end else begin
          tail_d = data_i;
        end
      end
      count_d = count_q + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign data_o  = (count_q != 2'd0) ? head_q : '0;
  assign count_o = count_q;

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch unit: PC, ROM addressing, fetch FSM
//
// Purpose: walks the PC through a synchronous instruction ROM, buffers the
// fetched words in a 2-entry FIFO and hands them to decode with a
// valid/ready handshake. Redirects flush and reload the PC; halt stops
// fetching until the next redirect.
// Ports:
//   clk             in   clock, rising edge
//   reset_n         in   asynchronous active-low reset
//   rom_addr        out  word address to the ROM (the PC register)
//   rom_data        in   ROM word for rom_addr, valid at the next rising edge
//   redirect_valid  in   flush and load redirect_pc
//   redirect_pc     in   new PC
//   halt_req        in   stop fetching until the next redirect
//   out_valid       out  out_instr/out_pc hold a fetched word
//   out_ready       in   decode accepts the head word
//   out_instr       out  fetched instruction
//   out_pc          out  address of out_instr
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 12,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned RESET_PC      = DEFAULT_RESET_PC
) (
  input  logic                     clk,
  input  logic                     reset_n,
  output logic [ADDRESS_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0]    rom_data,
  input  logic                     redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
  input  logic                     halt_req,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_instr,
  output logic [ADDRESS_WIDTH-1:0] out_pc
);

  localparam int unsigned ENTRY_W = ADDRESS_WIDTH + DATA_WIDTH;

  fetch_state_e             state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
  logic                     pop, fetch, flush;
  logic [1:0]               count;
  logic [ENTRY_W-1:0]       head;

  assign pop = out_valid && out_ready;

  // Redirect wins over everything: the word on rom_data belongs to the old
  // path, so it is dropped rather than pushed. A concurrent pop is still a
  // completed handshake from decode's point of view; the flush covers it.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fetch   = 1'b0;
    flush   = 1'b0;
    if (redirect_valid) begin
      flush   = 1'b1;
      pc_d    = redirect_pc;
      state_d = ST_RUN;
    end else begin
      unique case (state_q)
        // One idle edge so the ROM can present the word at RESET_PC.
        ST_BOOT: state_d = ST_RUN;
        ST_RUN: begin
          if (halt_req) begin
            state_d = ST_HALT;
          end else if ((count < 2'(FIFO_DEPTH)) || pop) begin
            fetch = 1'b1;
            pc_d  = pc_q + ADDRESS_WIDTH'(1);
          end
        end
        ST_HALT: state_d = ST_HALT;
        default: state_d = ST_BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_BOOT;
      pc_q    <= ADDRESS_WIDTH'(RESET_PC);
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  fetch_fifo #(
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (fetch),
    .pop_i   (pop),
    .flush_i (flush),
    .data_i  ({pc_q, rom_data}),
    .data_o  (head),
    .count_o (count)
  );

  assign rom_addr            = pc_q;
  assign out_valid           = (count != 2'd0);
  assign {out_pc, out_instr} = head;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch
module tb_instr_fetch;

  localparam int AW = 12;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n, redirect_valid, halt_req, out_ready, out_valid;
  logic [AW-1:0] rom_addr, redirect_pc, out_pc;
  logic [DW-1:0] rom_data, out_instr;

  logic          w_reset_n, w_redirect_valid, w_halt_req, w_out_ready, w_out_valid;
  logic [AW-1:0] w_rom_addr, w_redirect_pc, w_out_pc;
  logic [DW-1:0] w_rom_data, w_out_instr;

  instr_fetch dut (
    .clk(clk), .reset_n(reset_n), .rom_addr(rom_addr), .rom_data(rom_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt_req(halt_req),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc)
  );

  instr_fetch #(.ADDRESS_WIDTH(12), .DATA_WIDTH(32), .RESET_PC(12'hFFE)) dut_w (
    .clk(clk), .reset_n(w_reset_n), .rom_addr(w_rom_addr), .rom_data(w_rom_data),
    .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc), .halt_req(w_halt_req),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_instr(w_out_instr), .out_pc(w_out_pc)
  );

  function automatic logic [DW-1:0] rom_word(input int a);
    return DW'(a + 100);
  endfunction

  // ROM samples the address on the falling edge
  initial begin
    rom_data   = '0;
    w_rom_data = '0;
  end
  always @(negedge clk) begin
    rom_data   = rom_word(int'(rom_addr));
    w_rom_data = rom_word(int'(w_rom_addr));
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of fetched words, the next address to fetch,
  // and a mode (0 boot, 1 run, 2 halt).
  typedef struct {
    int          pc;
    logic [DW-1:0] instr;
  } ent_t;

  ent_t mq[$];
  int   mpc;
  int   mmode;

  function automatic void model_reset();
    mq.delete();
    mpc   = 0;
    mmode = 0;
  endfunction

  always @(posedge clk) begin : model
    bit   took;
    ent_t e;
    if (reset_n) begin
      took = (mq.size() > 0) && out_ready;
      if (took) void'(mq.pop_front());
      if (redirect_valid) begin
        mq.delete();
        mpc   = int'(redirect_pc);
        mmode = 1;
      end else if (mmode == 0) begin
        mmode = 1;
      end else if (mmode == 1) begin
        if (halt_req) begin
          mmode = 2;
        end else if (mq.size() < 2) begin
          e.pc    = mpc;
          e.instr = rom_word(mpc);
          mq.push_back(e);
          mpc = (mpc + 1) % (1 << AW);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      chk("m_valid", 64'(out_valid), 64'(mq.size() > 0));
      chk("m_rom_addr", 64'(rom_addr), 64'(mpc));
      if (mq.size() > 0) begin
        chk("m_out_pc", 64'(out_pc), 64'(mq[0].pc));
        chk("m_out_instr", 64'(out_instr), 64'(mq[0].instr));
      end else begin
        chk("m_idle_pc", 64'(out_pc), 64'd0);
        chk("m_idle_instr", 64'(out_instr), 64'd0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int last;

  initial begin
    reset_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; halt_req = 1'b0; out_ready = 1'b0;
    w_reset_n = 1'b0; w_redirect_valid = 1'b0; w_redirect_pc = '0; w_halt_req = 1'b0; w_out_ready = 1'b1;
    model_reset();
    step(); step();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_rom_addr", 64'(rom_addr), 64'd0);
    chk("rst_out_pc", 64'(out_pc), 64'd0);
    chk("rst_out_instr", 64'(out_instr), 64'd0);

    // Release: one boot edge, then one word per cycle from 0
    reset_n = 1'b1; out_ready = 1'b1;
    step(); chk("boot_valid", 64'(out_valid), 64'd0);
    step(); chk("first_valid", 64'(out_valid), 64'd1);
    chk("first_pc", 64'(out_pc), 64'd0);   chk("first_instr", 64'(out_instr), 64'd100);
    step(); chk("seq1_pc", 64'(out_pc), 64'd1); chk("seq1_instr", 64'(out_instr), 64'd101);
    step(); chk("seq2_pc", 64'(out_pc), 64'd2); chk("seq2_instr", 64'(out_instr), 64'd102);

    // Fill the FIFO, then reset between edges
    out_ready = 1'b0;
    repeat (3) step();
    reset_n = 1'b0; model_reset();
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_pc", 64'(rom_addr), 64'd0);
    step();
    reset_n = 1'b1;
    repeat (7) step();
    chk("stall_rom_addr", 64'(rom_addr), 64'd2);
    chk("stall_head", 64'(out_pc), 64'd0);
    out_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("drain_pc", 64'(out_pc), 64'(k));
      chk("drain_valid", 64'(out_valid), 64'd1);
    end

    // Redirect with a full FIFO
    out_ready = 1'b0;
    repeat (3) step();
    redirect_valid = 1'b1; redirect_pc = 12'h040;
    step();
    redirect_valid = 1'b0;
    chk("redir_flush_valid", 64'(out_valid), 64'd0);
    chk("redir_rom_addr", 64'(rom_addr), 64'h040);
    step();
    chk("redir_valid", 64'(out_valid), 64'd1);
    chk("redir_pc", 64'(out_pc), 64'h040);
    chk("redir_instr", 64'(out_instr), 64'h040 + 64'd100);

    // Halt when the PC reaches 5
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 12'h000;
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 20 && rom_addr != 12'd5; i++) step();
    chk("reach_pc5", 64'(rom_addr), 64'd5);
    last = -1;
    halt_req = 1'b1;
    if (out_valid) last = int'(out_pc);
    step();
    halt_req = 1'b0;
    repeat (6) begin
      if (out_valid) last = int'(out_pc);
      step();
    end
    chk("halt_last_pc", 64'(last), 64'd4);
    chk("halt_valid", 64'(out_valid), 64'd0);
    chk("halt_rom_addr", 64'(rom_addr), 64'd5);
    redirect_valid = 1'b1; redirect_pc = 12'h010;
    step();
    redirect_valid = 1'b0;
    step();
    chk("resume_pc", 64'(out_pc), 64'h010);

    // Randomised traffic against the model
    for (int i = 0; i < 3000; i++) begin
      out_ready      = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = AW'($urandom);
      halt_req       = ($urandom_range(0, 24) == 0);
      if (!reset_n) begin
        reset_n = 1'b1;
      end else if ($urandom_range(0, 499) == 0) begin
        reset_n = 1'b0;
        model_reset();
      end
      step();
    end
    reset_n = 1'b1; redirect_valid = 1'b0; halt_req = 1'b0; out_ready = 1'b1;

    // Wrap from RESET_PC=0xFFE; redirect beats a simultaneous halt
    w_reset_n = 1'b1;
    step();
    step();
    chk("w_pc0", 64'(w_out_pc), 64'hFFE); chk("w_instr0", 64'(w_out_instr), 64'hFFE + 64'd100);
    step(); chk("w_pc1", 64'(w_out_pc), 64'hFFF);
    step(); chk("w_pc2", 64'(w_out_pc), 64'h000); chk("w_instr2", 64'(w_out_instr), 64'd100);
    w_redirect_valid = 1'b1; w_halt_req = 1'b1; w_redirect_pc = 12'h123;
    step();
    w_redirect_valid = 1'b0; w_halt_req = 1'b0;
    chk("w_redir_flush", 64'(w_out_valid), 64'd0);
    step(); chk("w_redir_pc", 64'(w_out_pc), 64'h123);
    step(); chk("w_run_pc", 64'(w_out_pc), 64'h124);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
